wrr_burst_sched: RTL and testbench

WRR_BURST_SCHED -- requirements
Module: wrr_burst_sched

---
 rtl/wrr_burst_sched_pkg.sv | 16 +
 rtl/wrr_burst_sched_rr_pick.sv | 34 +++
 rtl/wrr_burst_sched.sv | 155 +++++++++++++++
 tb/tb_wrr_burst_sched.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wrr_burst_sched_pkg.sv
// Shared types and default sizing for the weighted round-robin
// burst scheduler.
package wrr_burst_sched_pkg;

    localparam int DEF_N        = 4;
    localparam int DEF_DW       = 32;
    localparam int DEF_WW       = 4;
    localparam int DEF_BEAT_MAX = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        XFER   = 2'd2
    } state_e;

endpackage

// File: rtl/wrr_burst_sched_rr_pick.sv
// Combinational rotating-priority picker: first set mask bit at or
// after ptr (wrapping) is returned one-hot.
module wrr_burst_sched_rr_pick
    import wrr_burst_sched_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int PW = $clog2(DEF_N)
) (
    input  logic [N-1:0]  mask,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    // Walk offsets from far to near so the nearest hit wins.
    function automatic logic [N-1:0] pick_fn(
        input logic [N-1:0]  m,
        input logic [PW-1:0] p
    );
        logic [N-1:0] g;
        int           j;
        g = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(p) + k) % N;
            if (m[j]) begin
                g    = '0;
                g[j] = 1'b1;
            end
        end
        return g;
    endfunction

    assign grant = pick_fn(mask, ptr);

endmodule

// File: rtl/wrr_burst_sched.sv
// Weighted round-robin burst scheduler: N masters share one slave
// port, bursts are locked to one owner and capped at BEAT_MAX beats.
module wrr_burst_sched
    import wrr_burst_sched_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int DW       = DEF_DW,
    parameter int WW       = DEF_WW,
    parameter int BEAT_MAX = DEF_BEAT_MAX
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [$clog2(N)-1:0] cfg_idx,
    input  logic [WW-1:0]        cfg_weight,
    input  logic [N-1:0]         m_valid,
    input  logic [N-1:0]         m_last,
    input  logic [N*DW-1:0]      m_data,
    output logic [N-1:0]         m_ready,
    output logic                 s_valid,
    output logic                 s_last,
    output logic [DW-1:0]        s_data,
    input  logic                 s_ready,
    output logic [N-1:0]         owner,
    output logic                 abort
);

    localparam int PW = $clog2(N);
    localparam int BW = (BEAT_MAX > 1) ? $clog2(BEAT_MAX) : 1;
    localparam logic [BW-1:0] BEAT_END = BW'(BEAT_MAX - 1);

    state_e        state_q, state_d;
    logic [N-1:0]  owner_q, owner_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [WW-1:0] credit_q [N];
    logic [WW-1:0] credit_d [N];
    logic [WW-1:0] weight_q [N];
    logic [WW-1:0] weight_d [N];

    logic [N-1:0]  has_credit;
    logic [N-1:0]  has_weight;
    logic [N-1:0]  eligible;
    logic [N-1:0]  pick;
    logic [PW-1:0] own_idx;
    logic          in_xfer;
    logic          cur_valid;
    logic          cur_last;
    logic          cnt_end;
    logic          accept;

    always_comb begin
        has_credit = '0;
        has_weight = '0;
        for (int i = 0; i < N; i++) begin
            has_credit[i] = credit_q[i] != '0;
            has_weight[i] = weight_q[i] != '0;
        end
    end

    assign eligible = m_valid & has_credit & has_weight;

    wrr_burst_sched_rr_pick #(
        .N  (N),
        .PW (PW)
    ) rr_pick (
        .mask  (eligible),
        .ptr   (ptr_q),
        .grant (pick)
    );

    always_comb begin
        own_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (owner_q[i]) own_idx = PW'(i);
        end
    end

    // Slave-side view of the owning master; quiet outside XFER.
    assign in_xfer   = state_q == XFER;
    assign cur_valid = m_valid[own_idx];
    assign cur_last  = m_last[own_idx];
    assign cnt_end   = beat_q == BEAT_END;
    assign s_valid   = in_xfer & cur_valid;
    assign s_last    = in_xfer & (cur_last | cnt_end);
    assign s_data    = in_xfer ? m_data[int'(own_idx)*DW +: DW] : '0;
    assign m_ready   = in_xfer ? (owner_q & {N{s_ready}}) : '0;
    assign accept    = s_valid & s_ready;
    assign abort     = accept & cnt_end & ~cur_last;
    assign owner     = owner_q;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        beat_d   = beat_q;
        credit_d = credit_q;
        weight_d = weight_q;
        unique case (state_q)
            IDLE: begin
                if (|eligible) begin
                    owner_d = pick;
                    beat_d  = '0;
                    state_d = XFER;
                end else if (|(m_valid & has_weight)) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                credit_d = weight_q;
                state_d  = IDLE;
            end
            XFER: begin
                if (accept) begin
                    beat_d = beat_q + 1'b1;
                    if (s_last) begin
                        if (credit_q[own_idx] != '0) begin
                            credit_d[own_idx] = credit_q[own_idx] - 1'b1;
                        end
                        ptr_d   = (own_idx == PW'(N - 1)) ? '0
                                                          : own_idx + 1'b1;
                        owner_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Weights land immediately; credits only follow on REFILL.
        if (cfg_we && (int'(cfg_idx) < N)) begin
            weight_d[cfg_idx] = cfg_weight;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            beat_q  <= '0;
            for (int i = 0; i < N; i++) begin
                credit_q[i] <= '0;
                weight_q[i] <= WW'(1);
            end
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            beat_q   <= beat_d;
            credit_q <= credit_d;
            weight_q <= weight_d;
        end
    end

endmodule

// File: tb/tb_wrr_burst_sched.sv
// Scoreboard bench for wrr_burst_sched: a behavioural model predicts
// per-cycle outputs and accepted beats, a monitor compares them.
module tb_wrr_burst_sched;

    localparam int N        = 4;
    localparam int DW       = 32;
    localparam int WW       = 4;
    localparam int BEAT_MAX = 16;
    localparam int PH_IDLE   = 0;
    localparam int PH_REFILL = 1;
    localparam int PH_XFER   = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            cfg_we = 1'b0;
    logic [1:0]      cfg_idx = '0;
    logic [WW-1:0]   cfg_weight = '0;
    logic [N-1:0]    m_valid = '0;
    logic [N-1:0]    m_last = '0;
    logic [N*DW-1:0] m_data = '0;
    logic [N-1:0]    m_ready;
    logic            s_valid;
    logic            s_last;
    logic [DW-1:0]   s_data;
    logic            s_ready = 1'b0;
    logic [N-1:0]    owner;
    logic            abort;

    always #5 clk = ~clk;

    wrr_burst_sched #(
        .N(N), .DW(DW), .WW(WW), .BEAT_MAX(BEAT_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_weight(cfg_weight),
        .m_valid(m_valid), .m_last(m_last), .m_data(m_data),
        .m_ready(m_ready),
        .s_valid(s_valid), .s_last(s_last), .s_data(s_data),
        .s_ready(s_ready), .owner(owner), .abort(abort)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [N-1:0] own;
        logic         sv;
        logic [N-1:0] mr;
        logic         ab;
    } cyc_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    cyc_t  cq[$];
    beat_t bq[$];

    // Reference model: one step per cycle from the rules of the block.
    int md_phase, md_own, md_beats, md_ptr;
    int md_credit[N];
    int md_weight[N];

    task automatic model_step();
        cyc_t  c;
        beat_t b;
        int    sel, j;
        bit    any_w, forced, lst;
        c.own = '0; c.sv = 1'b0; c.mr = '0; c.ab = 1'b0;
        if (!rst_n) begin
            md_phase = PH_IDLE; md_own = -1;
            md_beats = 0; md_ptr = 0;
            for (int i = 0; i < N; i++) begin
                md_credit[i] = 0; md_weight[i] = 1;
            end
            cq.push_back(c);
            return;
        end
        if (md_own >= 0) c.own[md_own] = 1'b1;
        case (md_phase)
            PH_IDLE: begin
                sel = -1; any_w = 0;
                for (int k = 0; k < N; k++) begin
                    j = (md_ptr + k) % N;
                    if (sel < 0 && m_valid[j] && md_credit[j] > 0
                        && md_weight[j] > 0) sel = j;
                    if (m_valid[k] && md_weight[k] > 0) any_w = 1;
                end
                if (sel >= 0) begin
                    md_own = sel; md_beats = 0; md_phase = PH_XFER;
                end else if (any_w) begin
                    md_phase = PH_REFILL;
                end
            end
            PH_REFILL: begin
                for (int i = 0; i < N; i++) md_credit[i] = md_weight[i];
                md_phase = PH_IDLE;
            end
            default: begin
                c.sv = m_valid[md_own];
                c.mr[md_own] = s_ready;
                if (m_valid[md_own] && s_ready) begin
                    forced = md_beats == BEAT_MAX - 1;
                    lst = m_last[md_own] || forced;
                    b.cyc = cyc;
                    b.data = m_data[md_own*DW +: DW];
                    b.last = lst;
                    bq.push_back(b);
                    c.ab = forced && !m_last[md_own];
                    md_beats++;
                    if (lst) begin
                        if (md_credit[md_own] > 0) md_credit[md_own]--;
                        md_ptr = (md_own + 1) % N;
                        md_own = -1;
                        md_phase = PH_IDLE;
                    end
                end
            end
        endcase
        cq.push_back(c);
        if (cfg_we) md_weight[cfg_idx] = int'(cfg_weight);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_step();
        end
    end

    int g[N];
    int bc[N];
    int aborts = 0;

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    initial begin
        cyc_t  c;
        beat_t b;
        int    o;
        forever begin
            @(negedge clk);
            #1;
            if (cq.size() == 0) begin
                checks++; errors++;
                $display("FAIL cycle_record: none expected at cycle %0d", cyc);
            end else begin
                c = cq.pop_front();
                chk("owner", owner, c.own);
                chk("s_valid", s_valid, c.sv);
                chk("m_ready", m_ready, c.mr);
                chk("abort", abort, c.ab);
            end
            if (s_valid && s_ready) begin
                o = oh_idx(owner);
                bc[o]++;
                if (abort) aborts++;
                if (s_last) g[o]++;
                if (bq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL beat: unexpected beat at cycle %0d", cyc);
                end else begin
                    b = bq.pop_front();
                    chk("beat_cycle", cyc, b.cyc);
                    chk("s_data", s_data, b.data);
                    chk("s_last", s_last, b.last);
                end
            end
        end
    end

    // Master traffic generator; bursts advance on observed handshakes.
    int            rem[N];
    logic [DW-1:0] dat[N];
    logic [N-1:0]  hs;
    logic [N-1:0]  en_mask = '1;
    int len_max = 1, valid_pct = 100, start_pct = 100, ready_pct = 100;

    task automatic drive_cycles(input int n);
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            hs = m_valid & m_ready;
            @(posedge clk);
            #1;
            cfg_we = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    rem[i]--;
                    dat[i] = $urandom;
                end
                if (rem[i] == 0 && en_mask[i]
                    && $urandom_range(0, 99) < start_pct)
                    rem[i] = $urandom_range(1, len_max);
                m_valid[i] = rem[i] > 0
                             && $urandom_range(0, 99) < valid_pct;
                m_last[i] = rem[i] == 1;
                m_data[i*DW +: DW] = dat[i];
            end
            s_ready = $urandom_range(0, 99) < ready_pct;
        end
    endtask

    task automatic cfg_write(input int idx, input int w);
        cfg_we = 1'b1;
        cfg_idx = 2'(idx);
        cfg_weight = WW'(w);
    endtask

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    logic [N-1:0] exp_own [13];
    int base, guard, snap, others;

    initial begin
        exp_own = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4,
                    4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h1};
        for (int i = 0; i < N; i++) begin
            rem[i] = 1; dat[i] = $urandom;
            g[i] = 0; bc[i] = 0;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_owner", owner, '0);
        chk("rst_s_valid", s_valid, 1'b0);
        chk("rst_s_last", s_last, 1'b0);
        chk("rst_m_ready", m_ready, '0);
        chk("rst_abort", abort, 1'b0);

        // All masters single-beat: refill, then one grant each in turn.
        m_valid = '1; m_last = '1; s_ready = 1'b1;
        for (int i = 0; i < N; i++) m_data[i*DW +: DW] = dat[i];
        rst_n = 1'b1;
        for (int k = 0; k < 13; k++) begin
            drive_cycles(1);
            chk($sformatf("rr_seq_%0d", k), owner, exp_own[k]);
        end

        // Weight 3 on m0: three grants per refill window vs one.
        cfg_write(0, 3);
        drive_cycles(20);
        for (int i = 0; i < N; i++) g[i] = 0;
        drive_cycles(140);
        chk("wrr_m1_active", g[1] >= 8, 1'b1);
        chk("wrr_m1_m3_even", absdiff(g[1], g[3]) <= 1, 1'b1);
        chk("wrr_m0_triple", absdiff(g[0], 3 * g[1]) <= 3, 1'b1);
        cfg_write(0, 1);

        // m2 alone with a 40-beat request: capped at 16 beats per burst.
        en_mask = '0; start_pct = 0;
        drive_cycles(30);
        rem[2] = 40; aborts = 0; base = bc[2];
        drive_cycles(80);
        chk("cap_abort_count", aborts, 2);
        chk("cap_m2_beats", bc[2] - base, 40);
        chk("cap_idle_after", owner, '0);

        // m1 four beats with a two-cycle slave stall mid-burst.
        rem[1] = 4; base = bc[1];
        drive_cycles(4);
        ready_pct = 0;
        drive_cycles(2);
        ready_pct = 100;
        drive_cycles(12);
        chk("stall_m1_beats", bc[1] - base, 4);
        chk("stall_owner_released", owner, '0);

        // Reset in the middle of an m0 burst, with ptr moved off 0.
        rem[0] = 1;
        drive_cycles(8);
        rem[0] = 10; base = bc[0]; guard = 0; aborts = 0;
        while (bc[0] < base + 2 && guard < 40) begin
            drive_cycles(1);
            guard++;
        end
        chk("m0_reached_beat3", bc[0] >= base + 2, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_owner", owner, '0);
        chk("mid_rst_s_valid", s_valid, 1'b0);
        chk("mid_rst_m_ready", m_ready, '0);
        chk("mid_rst_abort", abort, 1'b0);
        rem[1] = 1;
        drive_cycles(2);
        rst_n = 1'b1;
        drive_cycles(1);
        chk("post_rst_refill", owner, '0);
        drive_cycles(2);
        chk("post_rst_ptr0", owner, 4'h1);
        chk("post_rst_no_abort", aborts, 0);

        // Random traffic with occasional weight rewrites.
        en_mask = '1; start_pct = 60; valid_pct = 80;
        len_max = 20; ready_pct = 70;
        for (int blk = 0; blk < 30; blk++) begin
            drive_cycles(50);
            cfg_write($urandom_range(0, 3), $urandom_range(0, 3));
        end

        // m3 weight dropped to 0 mid-traffic: never granted afterwards.
        for (int i = 0; i < N; i++) begin
            cfg_write(i, 1);
            drive_cycles(1);
        end
        drive_cycles(50);
        cfg_write(3, 0);
        drive_cycles(40);
        snap = g[3];
        others = g[0] + g[1] + g[2];
        drive_cycles(300);
        chk("m3_excluded", g[3], snap);
        chk("others_progress", g[0] + g[1] + g[2] > others + 10, 1'b1);

        drive_cycles(2);
        chk("beat_queue_drained", bq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
